// File: rtl/temp_sensor_pkg.sv
// Shared types, frame constants and the raw-reading clamp for the
// temperature sensor reader.
package temp_sensor_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SHIFT,
      DONE
   } state_e;

   localparam int FRAME_BITS = 16;
   localparam int TEMP_MIN   = 0;
   localparam int TEMP_MAX   = 99;

   typedef struct packed {
      logic [7:0] temp;
      logic       oor;
   } reading_t;

   // Frame bits [15:7] carry a signed whole-degree value
   function automatic reading_t clamp_raw(
      input logic [FRAME_BITS-1:0] frame
   );
      logic signed [8:0] v;
      reading_t          r;
      v      = $signed(frame[FRAME_BITS-1:FRAME_BITS-9]);
      r.temp = v[7:0];
      r.oor  = 1'b0;
      if (int'(v) < TEMP_MIN) begin
         r.temp = 8'(TEMP_MIN);
         r.oor  = 1'b1;
      end else if (int'(v) > TEMP_MAX) begin
         r.temp = 8'(TEMP_MAX);
         r.oor  = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/temp_spi_rx.sv
// Serial-clock generator and 16-bit MSB-first receive shifter.
// Half 0 is the setup phase; halves 1..32 alternate sclk low/high.
module temp_spi_rx
   import temp_sensor_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  miso,
   output logic                  sclk,
   output logic                  setup_done,
   output logic                  frame_done,
   output logic [FRAME_BITS-1:0] data
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [5:0] HALF_LAST = 6'(2 * FRAME_BITS);

   logic [DIV_W-1:0]      div_q, div_d;
   logic [5:0]            half_q, half_d;
   logic                  sclk_q, sclk_d;
   logic [FRAME_BITS-1:0] shreg_q, shreg_d;
   logic                  wrap;
   logic                  last;

   always_comb begin
      div_d   = div_q;
      half_d  = half_q;
      sclk_d  = sclk_q;
      shreg_d = shreg_q;
      wrap    = (div_q == DIV_LAST);
      last    = wrap && (half_q == HALF_LAST);
      if (!en || last) begin
         div_d  = '0;
         half_d = '0;
         sclk_d = 1'b0;
      end else if (wrap) begin
         div_d  = '0;
         half_d = half_q + 6'd1;
         // Leaving an odd (low) half means sclk rises now
         sclk_d = half_q[0];
         if (half_q[0]) begin
            shreg_d = {shreg_q[FRAME_BITS-2:0], miso};
         end
      end else begin
         div_d = div_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q   <= '0;
         half_q  <= '0;
         sclk_q  <= 1'b0;
         shreg_q <= '0;
      end else begin
         div_q   <= div_d;
         half_q  <= half_d;
         sclk_q  <= sclk_d;
         shreg_q <= shreg_d;
      end
   end

   assign sclk       = sclk_q;
   assign data       = shreg_q;
   assign setup_done = en && wrap && (half_q == 6'd0);
   assign frame_done = en && last;

endmodule

// File: rtl/temp_sensor_reader.sv
// Periodic SPI temperature reader with clamp to 0..99.
// Define TEMP_AVG_EN to output the mean of the last 4 readings.
module temp_sensor_reader
   import temp_sensor_pkg::*;
#(
   parameter int CLK_DIV       = 4,
   parameter int SAMPLE_PERIOD = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       miso,
   output logic       cs_n,
   output logic       sclk,
   output logic [7:0] temperature,
   output logic       temp_valid,
   output logic       out_of_range,
   output logic       busy
);

   localparam int CNT_W = $clog2(SAMPLE_PERIOD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [7:0]            temp_q, temp_d;
   logic                  oor_q, oor_d;
   logic                  valid_q, valid_d;
   logic                  en;
   logic                  setup_done;
   logic                  frame_done;
   logic [FRAME_BITS-1:0] rx_data;
   reading_t              rd;
`ifdef TEMP_AVG_EN
   logic [3:0][7:0]       hist_q, hist_d;
   logic                  filled_q, filled_d;
   logic [8:0]            sum;
`endif

   assign en = (state_q == SETUP) || (state_q == SHIFT);

   temp_spi_rx #(
      .CLK_DIV(CLK_DIV)
   ) u_rx (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .miso       (miso),
      .sclk       (sclk),
      .setup_done (setup_done),
      .frame_done (frame_done),
      .data       (rx_data)
   );

   always_comb begin
      cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      state_d = state_q;
      temp_d  = temp_q;
      oor_d   = oor_q;
      valid_d = 1'b0;
      rd      = clamp_raw(rx_data);
`ifdef TEMP_AVG_EN
      hist_d   = hist_q;
      filled_d = filled_q;
      sum      = '0;
`endif
      unique case (state_q)
         IDLE: if (cnt_q == CNT_LAST) state_d = SETUP;
         SETUP: if (setup_done) state_d = SHIFT;
         SHIFT: if (frame_done) state_d = DONE;
         DONE: begin
            state_d = IDLE;
            valid_d = 1'b1;
            oor_d   = rd.oor;
`ifdef TEMP_AVG_EN
            // First reading after reset seeds the whole history
            hist_d   = filled_q ? {hist_q[2:0], rd.temp}
                                : {4{rd.temp}};
            filled_d = 1'b1;
            sum      = 9'(hist_d[0]) + 9'(hist_d[1])
                     + 9'(hist_d[2]) + 9'(hist_d[3]);
            temp_d   = 8'(sum >> 2);
`else
            temp_d   = rd.temp;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         temp_q  <= '0;
         oor_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         temp_q  <= temp_d;
         oor_q   <= oor_d;
         valid_q <= valid_d;
      end
   end

`ifdef TEMP_AVG_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q   <= '0;
         filled_q <= 1'b0;
      end else begin
         hist_q   <= hist_d;
         filled_q <= filled_d;
      end
   end
`endif

   assign cs_n         = !en;
   assign busy         = en;
   assign temperature  = temp_q;
   assign out_of_range = oor_q;
   assign temp_valid   = valid_q;

endmodule
